hex_display_ctrl: RTL

- Parametrised Avalon-MM slave driving NUM_DIGITS active-low 7-segment displays; replaces the per-digit PIO output ports.
- Per-digit mode: either a hex nibble decoded in hardware, or raw segment bits.
- Adds per-digit blinking, a global display enable and, optionally, PWM brightness dimming.
- Sits inside the Nios system; segment outputs go straight to the HEXn board pins.

---
 rtl/hex_display_pkg.sv | 31 +++
 rtl/hex7_decode.sv | 11 +
 rtl/hex_display_ctrl.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/hex_display_pkg.sv
// Shared constants for hex_display_ctrl: register offsets, field positions,
// blanking pattern and the hex-to-segment table.
package hex_display_pkg;

  // Register offsets. Digits sit at 0..nd-1, followed by CTRL and BLINK_MASK.
  localparam int DIGIT_BASE = 0;

  function automatic int ctrl_ofs(input int nd);
    return nd;
  endfunction

  function automatic int mask_ofs(input int nd);
    return nd + 1;
  endfunction

  // Field positions
  localparam int RAW_BIT     = 7;
  localparam int DISP_EN_BIT = 0;
  localparam int DUTY_LSB    = 4;
  localparam int DUTY_MSB    = 7;

  // All segments off (outputs are active-low)
  localparam logic [6:0] BLANK_SEGS = 7'h7F;

  // Active-low segments, bit order g..a. Entry 0 is the rightmost.
  //                                       F      E      d      C      b      A      9      8
  localparam logic [15:0][6:0] HEX_TABLE = {7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
  //                                       7      6      5      4      3      2      1      0
                                            7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40};

endpackage

// File: rtl/hex7_decode.sv
// Combinational 4-bit hex value to active-low 7-segment pattern (g..a).
module hex7_decode
  import hex_display_pkg::*;
(
  input  logic [3:0] value,
  output logic [6:0] segs
);

  assign segs = HEX_TABLE[value];

endmodule

// File: rtl/hex_display_ctrl.sv
// Avalon-MM slave driving NUM_DIGITS active-low 7-segment displays.
// Per-digit hex decode or raw segments, per-digit blink, global enable.
// Optional PWM brightness dimming: define HEX_DISPLAY_PWM_DIM_EN.
module hex_display_ctrl
  import hex_display_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int BLINK_DIV  = 25000000,
  parameter int PWM_DIV    = 64,
  parameter int ADDR_W     = 5
) (
  input  logic                    clk_0,
  input  logic                    reset,
  input  logic [ADDR_W-1:0]       address,
  input  logic                    write,
  input  logic [31:0]             writedata,
  input  logic                    read,
  output logic [31:0]             readdata,
  output logic                    readdatavalid,
  output logic [NUM_DIGITS*7-1:0] hex_segs
);

  localparam int CTRL_A = ctrl_ofs(NUM_DIGITS);
  localparam int MASK_A = mask_ofs(NUM_DIGITS);

  logic [NUM_DIGITS-1:0][7:0] digit_q;
  logic [NUM_DIGITS-1:0]      mask_q;
  logic                       disp_en_q;
  logic [3:0]                 duty_rd;
  logic                       pwm_on;
  logic [31:0]                blink_cnt;
  logic                       blink_phase;
  logic [NUM_DIGITS-1:0][6:0] dec_segs;
  logic [NUM_DIGITS-1:0][6:0] seg_nxt;
  logic [31:0]                rd_mux;

  logic wr_ctrl, wr_mask, rd_accept;
  assign wr_ctrl   = write && (address == ADDR_W'(CTRL_A));
  assign wr_mask   = write && (address == ADDR_W'(MASK_A));
  // A read colliding with a write is dropped.
  assign rd_accept = read && !write;

  // Only the low byte / low mask bits are stored; the rest of the bus is ignored.
  logic unused_wdata;
  assign unused_wdata = ^writedata;

  // Per-digit storage, decode and blanking
  genvar d;
  generate
    for (d = 0; d < NUM_DIGITS; d++) begin : g_digit
      logic wr_dig;
      logic blank;
      assign wr_dig = write && (address == ADDR_W'(DIGIT_BASE + d));

      // Digit register write
      always_ff @(posedge clk_0 or posedge reset) begin
        if (reset)       digit_q[d] <= 8'h00;
        else if (wr_dig) digit_q[d] <= writedata[7:0];
      end

      hex7_decode u_dec (
        .value (digit_q[d][3:0]),
        .segs  (dec_segs[d])
      );

      assign blank = !disp_en_q || (mask_q[d] && blink_phase) || !pwm_on;

      // RAW digits carry active-high segment bits; flip them for the pins.
      always_comb begin
        seg_nxt[d] = digit_q[d][RAW_BIT] ? ~digit_q[d][6:0] : dec_segs[d];
        if (blank) seg_nxt[d] = BLANK_SEGS;
      end
    end
  endgenerate

  // CTRL enable and blink mask registers
  always_ff @(posedge clk_0 or posedge reset) begin
    if (reset) begin
      disp_en_q <= 1'b0;
      mask_q    <= '0;
    end else begin
      if (wr_ctrl) disp_en_q <= writedata[DISP_EN_BIT];
      if (wr_mask) mask_q    <= writedata[NUM_DIGITS-1:0];
    end
  end

  // Free-running blink prescaler; phase flips each half-period.
  always_ff @(posedge clk_0 or posedge reset) begin
    if (reset) begin
      blink_cnt   <= 32'h0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == 32'(BLINK_DIV - 1)) begin
      blink_cnt   <= 32'h0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt   <= blink_cnt + 32'h1;
    end
  end

`ifdef HEX_DISPLAY_PWM_DIM_EN
  logic [3:0]  duty_q;
  logic [31:0] pwm_pre;
  logic [3:0]  pwm_cnt;

  // Duty register
  always_ff @(posedge clk_0 or posedge reset) begin
    if (reset)        duty_q <= 4'hF;
    else if (wr_ctrl) duty_q <= writedata[DUTY_MSB:DUTY_LSB];
  end

  // PWM prescaler and 16-step brightness counter
  always_ff @(posedge clk_0 or posedge reset) begin
    if (reset) begin
      pwm_pre <= 32'h0;
      pwm_cnt <= 4'h0;
    end else if (pwm_pre == 32'(PWM_DIV - 1)) begin
      pwm_pre <= 32'h0;
      pwm_cnt <= pwm_cnt + 4'h1;
    end else begin
      pwm_pre <= pwm_pre + 32'h1;
    end
  end

  assign pwm_on  = (pwm_cnt <= duty_q);
  assign duty_rd = duty_q;
`else
  assign pwm_on  = 1'b1;
  assign duty_rd = 4'h0;
`endif

  // Read data mux; unmapped addresses return zero.
  always_comb begin
    rd_mux = 32'h0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (address == ADDR_W'(DIGIT_BASE + i)) rd_mux = {24'h0, digit_q[i]};
    if (address == ADDR_W'(CTRL_A)) rd_mux = {24'h0, duty_rd, 3'b000, disp_en_q};
    if (address == ADDR_W'(MASK_A)) rd_mux = {{(32-NUM_DIGITS){1'b0}}, mask_q};
  end

  // One-cycle read response
  always_ff @(posedge clk_0 or posedge reset) begin
    if (reset) begin
      readdata      <= 32'h0;
      readdatavalid <= 1'b0;
    end else begin
      readdata      <= rd_accept ? rd_mux : 32'h0;
      readdatavalid <= rd_accept;
    end
  end

  // Registered segment outputs
  always_ff @(posedge clk_0 or posedge reset) begin
    if (reset) hex_segs <= '1;
    else       hex_segs <= seg_nxt;
  end

endmodule
